mux_n_to_1_reg: RTL
===================

// Module: mux_n_to_1_reg
// PURPOSE
//  Parametrised N-channel, WIDTH-bit registered selector with valid/ready handshake.
//  Two modes: fixed select by sel, or round-robin across channels whose valid is high.
//  One output register stage; carries the granted channel index with the data.
//  Next generation of the ALU result-select muxes; feeds pipelined datapath stages.
// PARAMETERS
//  WIDTH     32  data bits per channel
//  CHANNELS  32  number of input channels (>=2)
//  SEL_W     5   select/index width = $clog2(CHANNELS)
// PORTS
//  clk        in   1               rising-edge clock
//  rst_n      in   1               asynchronous, active-low reset
//  in_data    in   CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
//  in_valid   in   CHANNELS        per-channel data valid
//  in_ready   out  CHANNELS        per-channel accept; one-hot or zero
//  mode       in   1               0 = fixed select, 1 = round-robin
//  sel        in   SEL_W           channel to forward in fixed mode
//  out_data   out  WIDTH           registered selected data
//  out_chan   out  SEL_W           channel index of out_data
//  out_valid  out  1               out_data/out_chan valid
//  out_ready  in   1               downstream accept
//  sel_err    out  1               sticky: fixed-mode sel >= CHANNELS seen; cleared by reset only
// BEHAVIOUR
//  - Reset, async on rst_n low: out_valid=0, out_data=0, out_chan=0, sel_err=0, rr_ptr=CHANNELS-1.
//    in_ready=0 while rst_n low.
//  - Output stage can load when load_en = !out_valid || out_ready.
//  - Grant, combinational each cycle:
//    - Fixed mode: grant=sel when sel<CHANNELS and in_valid[sel]; otherwise no grant.
//    - Round-robin mode: search from rr_ptr+1 upward, wrapping CHANNELS-1 -> 0, for the first i with in_valid[i].
//      No valid channel means no grant.
//  - in_ready[g] = load_en && grant valid. All other in_ready bits are 0.
//  - Transfer in: in_valid[g] && in_ready[g]. The output register loads in_data[g] and g, and sets out_valid=1.
//    rr_ptr <= g in both modes.
//  - load_en with no grant: out_valid <= 0; out_data and out_chan hold.
//  - out_valid && !out_ready: out_data, out_chan and out_valid hold. No input is accepted. Inputs must hold until accepted.
//  - Latency: 1 cycle from input transfer to out_valid. Throughput: 1 word/cycle when out_ready=1.
//  - mode and sel are sampled combinationally every cycle. A change applies from that cycle; no flush.
//  - sel_err sets in any cycle with mode=0 and sel>=CHANNELS (only reachable when CHANNELS is not a power of 2).
//  - Reset asserted mid-transfer: the word in flight is dropped; no partial state remains.
// TESTING
//  1 Reset, then fixed mode, sel=5, in_valid=all 1, in_data[5]=32'hA5A5_0005, out_ready=1
//    -> next cycle out_valid=1, out_data=A5A5_0005, out_chan=5; only in_ready[5] was high.
//  2 Round-robin, in_valid bits {3,7,31} high, out_ready=1
//    -> out_chan sequence 3,7,31,3,7 on consecutive cycles (wrap after 31).
//  3 Round-robin, all valid, out_ready=0 for 3 cycles after the first word
//    -> out_data/out_chan frozen, in_ready=0 throughout; after release the next chan is the previous chan+1.
//  4 Fixed mode, sel=9, in_valid[9]=0 -> no transfer; out_valid drops after the pending word drains.
//    Raise in_valid[9] -> word appears 1 cycle later.
//  5 CHANNELS=24, fixed mode, sel=26 -> no grant, in_ready=0, sel_err=1 and stays 1 after sel=0.
//  6 rst_n low mid-stream in round-robin with out_valid=1
//    -> out_valid=0 immediately; after release the first grant is the lowest valid channel, e.g. 0.

Source files
------------

// File: rtl/mux_n_to_1_reg.sv
// -----------------------------------------------------------------------------
// mux_n_to_1_reg
//   N-channel, WIDTH-bit registered selector with a valid/ready handshake on
//   every input channel and on the output. Two selection modes:
//     mode = 0 : fixed select, forwards channel `sel` whenever it is valid
//     mode = 1 : round-robin across the channels whose in_valid is high,
//                starting the search one past the last granted channel
//   A single output register stage carries the data together with the index
//   of the channel it came from.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous, active-low reset
//   in_data    CHANNELS*WIDTH packed input words, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel accept (one-hot or zero)
//   mode       0 = fixed select, 1 = round-robin
//   sel        fixed-mode channel select
//   out_data   registered selected word
//   out_chan   channel index of out_data
//   out_valid  out_data / out_chan valid
//   out_ready  downstream accept
//   sel_err    sticky flag: fixed mode was used with sel >= CHANNELS
// -----------------------------------------------------------------------------
module mux_n_to_1_reg #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 32,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      sel_err
);

    // One extra bit so the range check also works when CHANNELS == 2**SEL_W.
    localparam logic [SEL_W:0]   CH_LIM  = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

    logic [WIDTH-1:0] chan_data [CHANNELS];

    logic [WIDTH-1:0] out_data_reg;
    logic [SEL_W-1:0] out_chan_reg;
    logic             out_valid_reg;
    logic [SEL_W-1:0] rr_ptr_reg;
    logic             sel_err_reg;

    logic             load_en;
    logic             sel_in_range;
    logic             fix_hit;
    logic             rr_hit;
    logic [SEL_W-1:0] rr_idx;
    logic             grant_vld;
    logic [SEL_W-1:0] grant_idx;

    // Unpack the flat input bus into one word per channel.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_unpack
        assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
    end

    assign load_en      = !out_valid_reg || out_ready;
    assign sel_in_range = ({1'b0, sel} < CH_LIM);
    assign fix_hit      = sel_in_range && in_valid[sel];

    // Round-robin search: walk the channels starting one past the last
    // grant, wrapping at CHANNELS, and keep the first valid one found.
    always_comb begin
        int p;
        rr_hit = 1'b0;
        rr_idx = '0;
        p      = 0;
        for (int k = 1; k <= CHANNELS; k++) begin
            p = int'(rr_ptr_reg) + k;
            if (p >= CHANNELS) begin
                p = p - CHANNELS;
            end
            if (!rr_hit && in_valid[p]) begin
                rr_hit = 1'b1;
                rr_idx = p[SEL_W-1:0];
            end
        end
    end

    assign grant_vld = mode ? rr_hit : fix_hit;
    assign grant_idx = mode ? rr_idx : sel;

    // in_ready is gated by rst_n so nothing is offered while reset is held.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ready
        assign in_ready[gi] = rst_n && load_en && grant_vld &&
                              (grant_idx == SEL_W'(gi));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_reg  <= '0;
            out_chan_reg  <= '0;
            out_valid_reg <= 1'b0;
            rr_ptr_reg    <= LAST_CH;
            sel_err_reg   <= 1'b0;
        end else begin
            if (load_en) begin
                if (grant_vld) begin
                    out_data_reg  <= chan_data[grant_idx];
                    out_chan_reg  <= grant_idx;
                    out_valid_reg <= 1'b1;
                    rr_ptr_reg    <= grant_idx;
                end else begin
                    // Nothing to forward: drop valid, keep last data/chan.
                    out_valid_reg <= 1'b0;
                end
            end
            if (!mode && !sel_in_range) begin
                sel_err_reg <= 1'b1;
            end
        end
    end

    assign out_data  = out_data_reg;
    assign out_chan  = out_chan_reg;
    assign out_valid = out_valid_reg;
    assign sel_err   = sel_err_reg;

endmodule
